// File: rtl/pipeline_signals_pkg.sv
// Pipeline control types and constants shared by the MEM stage and its
// load/store alignment helper.
package pipeline_signals;

    // Memory-side control carried in the EX/MEM pipeline register
    typedef struct packed {
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] MemWidth;
        logic       MemUnsigned;
    } MEM_Control_t;

    // Writeback-side control carried through to MEM/WB
    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
    } WB_Control_t;

    localparam logic [1:0] MEMWIDTH_B = 2'd0;
    localparam logic [1:0] MEMWIDTH_H = 2'd1;
    localparam logic [1:0] MEMWIDTH_W = 2'd2;

    // Data-memory handshake progress
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    // True when the control word asks for any data-memory access
    function automatic logic is_mem_op(input MEM_Control_t ctrl);
        return ctrl.MemRead | ctrl.MemWrite;
    endfunction

endpackage

// File: rtl/stage_memory_load_store_align.sv
// Combinational lane handling for the data-memory port: byte enables,
// store-data replication, load extraction/extension and alignment check.
module load_store_align
    import pipeline_signals::*;
(
    input  MEM_Control_t mem_control,
    input  logic [1:0]   byte_offset,
    input  logic [31:0]  store_value,
    input  logic [31:0]  load_word,
    output logic [3:0]   byte_en,
    output logic [31:0]  write_data,
    output logic [31:0]  load_value,
    output logic         misaligned
);

    logic [31:0] load_shifted;

    // Widen an 8-bit lane to 32 bits, signed or unsigned
    function automatic logic [31:0] extend_byte(input logic [7:0] value, input logic zero_ext);
        return zero_ext ? {24'h0, value} : {{24{value[7]}}, value};
    endfunction

    // Widen a 16-bit lane to 32 bits, signed or unsigned
    function automatic logic [31:0] extend_half(input logic [15:0] value, input logic zero_ext);
        return zero_ext ? {16'h0, value} : {{16{value[15]}}, value};
    endfunction

    // Byte enables and replicated store data; width 3 is treated as a word
    always_comb begin
        byte_en    = 4'b1111;
        write_data = store_value;
        case (mem_control.MemWidth)
            MEMWIDTH_B: begin
                byte_en    = 4'b0001 << byte_offset;
                write_data = {4{store_value[7:0]}};
            end
            MEMWIDTH_H: begin
                byte_en    = 4'b0011 << byte_offset;
                write_data = {2{store_value[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                write_data = store_value;
            end
        endcase
    end

    // Move the addressed lane down to bit 0 before extension
    assign load_shifted = load_word >> {byte_offset, 3'b000};

    // Extract and extend the loaded lane
    always_comb begin
        load_value = load_shifted;
        case (mem_control.MemWidth)
            MEMWIDTH_B: load_value = extend_byte(load_shifted[7:0], mem_control.MemUnsigned);
            MEMWIDTH_H: load_value = extend_half(load_shifted[15:0], mem_control.MemUnsigned);
            default:    load_value = load_shifted;
        endcase
    end

    // Halfwords need even addresses, words need 4-byte alignment
    always_comb begin
        misaligned = 1'b0;
        if (is_mem_op(mem_control)) begin
            case (mem_control.MemWidth)
                MEMWIDTH_B: misaligned = 1'b0;
                MEMWIDTH_H: misaligned = byte_offset[0];
                default:    misaligned = |byte_offset;
            endcase
        end
    end

endmodule

// File: rtl/stage_memory.sv
// MEM stage of the RV32I pipeline: drives the valid/ready data-memory port,
// stalls upstream while a transaction is outstanding and registers MEM/WB.
module stage_memory
    import pipeline_signals::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic         i_Clock,
    input  logic         i_Reset_n,
    input  MEM_Control_t i_MEM_Control,
    input  WB_Control_t  i_WB_Control,
    input  logic [31:0]  i_AluOutput,
    input  logic [31:0]  i_rs2Value,
    output logic         o_Stall,
    output logic         o_DMem_Valid,
    output logic         o_DMem_Write,
    output logic [31:0]  o_DMem_Addr,
    output logic [3:0]   o_DMem_ByteEn,
    output logic [31:0]  o_DMem_WData,
    input  logic         i_DMem_Ready,
    input  logic         i_DMem_RspValid,
    input  logic [31:0]  i_DMem_RData,
    output WB_Control_t  o_WB_Control,
    output logic [31:0]  o_AluOutput,
    output logic [31:0]  o_MemReadData,
    output logic         o_Misaligned,
    output logic         o_BusError
);

    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int               CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);

    mem_state_t       state_q;
    mem_state_t       state_d;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             timeout_hit;

    logic             mem_op;
    logic             misaligned;
    logic [31:0]      load_value;

    logic             stall;
    logic             dmem_valid;
    logic             bubble;
    logic             retire_load;
    logic             misalign_evt;
    logic             timeout_evt;

    WB_Control_t      wb_ctrl_p1;
    logic [31:0]      alu_out_p1;
    logic [31:0]      mem_rdata_p1;
    logic             misaligned_p1;
    logic             bus_err_p1;

    assign mem_op = is_mem_op(i_MEM_Control);

    load_store_align u_align (
        .mem_control (i_MEM_Control),
        .byte_offset (i_AluOutput[1:0]),
        .store_value (i_rs2Value),
        .load_word   (i_DMem_RData),
        .byte_en     (o_DMem_ByteEn),
        .write_data  (o_DMem_WData),
        .load_value  (load_value),
        .misaligned  (misaligned)
    );

    // The counter saturates at the limit, so a read accepted exactly on the
    // limit cycle still times out on its first RESP cycle without data.
    assign timeout_hit = TIMEOUT_EN && (state_q != MEM_IDLE) && (tmo_cnt_q == CNT_LIMIT);

    // Handshake state register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Count cycles spent waiting in REQ/RESP; cleared whenever IDLE is involved
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tmo_cnt_q <= '0;
        end else if (!TIMEOUT_EN || state_q == MEM_IDLE || state_d == MEM_IDLE) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != CNT_LIMIT) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    // Next state, port valid, stall and retire qualifiers; a completing
    // handshake takes priority over a timeout in the same cycle
    always_comb begin
        state_d      = state_q;
        dmem_valid   = 1'b0;
        stall        = 1'b0;
        bubble       = 1'b0;
        retire_load  = 1'b0;
        misalign_evt = 1'b0;
        timeout_evt  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (misaligned) begin
                    misalign_evt = 1'b1;
                    bubble       = 1'b1;
                end else if (mem_op) begin
                    dmem_valid = 1'b1;
                    if (!i_DMem_Ready) begin
                        state_d = MEM_REQ;
                        stall   = 1'b1;
                    end else if (!i_MEM_Control.MemWrite) begin
                        state_d = MEM_RESP;
                        stall   = 1'b1;
                    end
                end
            end
            MEM_REQ: begin
                dmem_valid = 1'b1;
                if (i_DMem_Ready) begin
                    if (i_MEM_Control.MemWrite) begin
                        state_d = MEM_IDLE;
                    end else begin
                        state_d = MEM_RESP;
                        stall   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d     = MEM_IDLE;
                    timeout_evt = 1'b1;
                    bubble      = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            MEM_RESP: begin
                if (i_DMem_RspValid) begin
                    state_d     = MEM_IDLE;
                    retire_load = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = MEM_IDLE;
                    timeout_evt = 1'b1;
                    bubble      = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    assign o_Stall      = stall;
    assign o_DMem_Valid = dmem_valid;
    assign o_DMem_Write = i_MEM_Control.MemWrite;
    assign o_DMem_Addr  = {i_AluOutput[31:2], 2'b00};

    // ---- MEM -> WB boundary (_p1) ----
    // Stalled cycles insert a bubble and hold data; event flags are one-cycle pulses
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wb_ctrl_p1    <= '0;
            alu_out_p1    <= '0;
            mem_rdata_p1  <= '0;
            misaligned_p1 <= 1'b0;
            bus_err_p1    <= 1'b0;
        end else begin
            misaligned_p1 <= misalign_evt;
            bus_err_p1    <= timeout_evt;
            if (stall) begin
                wb_ctrl_p1 <= '0;
            end else begin
                wb_ctrl_p1 <= bubble ? WB_Control_t'('0) : i_WB_Control;
                alu_out_p1 <= i_AluOutput;
                if (retire_load) begin
                    mem_rdata_p1 <= load_value;
                end
            end
        end
    end

    assign o_WB_Control  = wb_ctrl_p1;
    assign o_AluOutput   = alu_out_p1;
    assign o_MemReadData = mem_rdata_p1;
    assign o_Misaligned  = misaligned_p1;
    assign o_BusError    = bus_err_p1;

endmodule

// File: tb/tb_stage_memory.sv
// Randomised scoreboard bench for stage_memory with a byte-level memory model.
module tb_stage_memory;
    import pipeline_signals::*;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    MEM_Control_t mem_ctl;
    WB_Control_t  wb_ctl;
    logic [31:0]  alu, rs2;
    logic         stall, valid, wr, rdy, rspv;
    logic [31:0]  addr, wdata, rdata;
    logic [3:0]   be;
    WB_Control_t  wb_out;
    logic [31:0]  alu_out, rd_out;
    logic         mis_out, berr_out;

    always #5 clk = ~clk;

    stage_memory #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_MEM_Control(mem_ctl), .i_WB_Control(wb_ctl),
        .i_AluOutput(alu), .i_rs2Value(rs2),
        .o_Stall(stall), .o_DMem_Valid(valid), .o_DMem_Write(wr),
        .o_DMem_Addr(addr), .o_DMem_ByteEn(be), .o_DMem_WData(wdata),
        .i_DMem_Ready(rdy), .i_DMem_RspValid(rspv), .i_DMem_RData(rdata),
        .o_WB_Control(wb_out), .o_AluOutput(alu_out), .o_MemReadData(rd_out),
        .o_Misaligned(mis_out), .o_BusError(berr_out)
    );

    typedef struct {
        bit rd; bit wr; logic [1:0] w; bit uns; logic [1:0] wb;
        logic [31:0] a; logic [31:0] d; int rw; int sw; bit hang; bit hreq;
    } ins_t;
    typedef struct {
        logic [1:0] wb; logic [31:0] alu; logic [31:0] rdata; bit mis; bit berr; int stalls;
    } exp_t;
    typedef struct {
        logic [31:0] addr; bit wr; logic [3:0] be; logic [31:0] wdata;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [0:63];
    logic [31:0] smem [0:15];
    logic [31:0] last_load = 32'h0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic ins_t mk(bit rd, bit wrt, logic [1:0] w, bit uns, logic [1:0] wb,
                                logic [31:0] a, logic [31:0] d, int rw, int sw, bit hang, bit hreq);
        ins_t i;
        i.rd = rd; i.wr = wrt; i.w = w; i.uns = uns; i.wb = wb; i.a = a; i.d = d;
        i.rw = rw; i.sw = sw; i.hang = hang; i.hreq = hreq;
        return i;
    endfunction

    // Reference model: outcome of one instruction from the architectural rules
    task automatic predict(input ins_t in);
        exp_t e; req_t r; int n, off, idx; logic [31:0] v;
        e.wb = in.wb; e.alu = in.a; e.rdata = last_load; e.mis = 0; e.berr = 0; e.stalls = 0;
        if (!in.rd && !in.wr) begin exp_q.push_back(e); return; end
        n = (in.w == 2'd0) ? 1 : (in.w == 2'd1) ? 2 : 4;
        off = int'(in.a % 4);
        idx = int'(in.a[5:0]);
        if ((in.a % n) != 0) begin
            e.wb = 2'b00; e.mis = 1; exp_q.push_back(e); return;
        end
        r.addr = in.a & 32'hFFFF_FFFC; r.wr = in.wr;
        r.be = 4'(((1 << n) - 1) << off);
        r.wdata = (n == 1) ? {4{in.d[7:0]}} : (n == 2) ? {2{in.d[15:0]}} : in.d;
        req_q.push_back(r);
        if (in.hang) begin
            e.wb = 2'b00; e.berr = 1; e.stalls = TMO + 1;
        end else if (in.wr) begin
            e.stalls = in.rw;
            for (int k = 0; k < n; k++) ref_mem[idx + k] = in.d[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[idx + k]) << (8 * k));
            if (!in.uns && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!in.uns && n == 2) v = {{16{v[15]}}, v[15:0]};
            last_load = v; e.rdata = v; e.stalls = in.rw + 1 + in.sw;
        end
        exp_q.push_back(e);
    endtask

    // Drive one instruction (called just after a rising edge) and act as the memory
    task automatic run(input ins_t in);
        int cyc, rq, rs; bit rsp_pend, st;
        mem_ctl.MemRead = in.rd; mem_ctl.MemWrite = in.wr;
        mem_ctl.MemWidth = in.w; mem_ctl.MemUnsigned = in.uns;
        wb_ctl = in.wb; alu = in.a; rs2 = in.d;
        predict(in);
        #1;
        cyc = 0; rq = 0; rs = 0; rsp_pend = 0;
        forever begin
            rdy = 0; rspv = 0; rdata = $urandom;
            if (rsp_pend) begin
                if (!in.hang && rs == in.sw) begin rspv = 1; rdata = smem[in.a[5:2]]; end
                else rs++;
            end else begin
                if (valid) begin
                    if (!(in.hang && in.hreq) && rq == in.rw) begin
                        rdy = 1;
                        if (wr) begin
                            for (int b = 0; b < 4; b++)
                                if (be[b]) smem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
                        end else rsp_pend = 1;
                    end else rq++;
                end
                if (!rdy) rspv = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk); st = stall;
            @(posedge clk); #1;
            cyc++;
            if (!st) break;
            if (cyc > 40) begin
                errors++;
                $display("FAIL stall_budget: actual=%0d cycles required=<=40", cyc);
                break;
            end
        end
    endtask

    // Retirement monitor: one scoreboard entry per non-stalled edge
    bit ret_pend = 0, was_stall = 0;
    int stall_run = 0, ret_stalls = 0;
    always @(negedge clk) begin
        exp_t e; logic [1:0] wbv;
        if (mon_en) begin
            wbv = wb_out;
            if (ret_pend) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_retire: actual=retire required=none");
                end else begin
                    e = exp_q.pop_front();
                    check("wb_ctrl", 32'(wbv), 32'(e.wb));
                    check("alu_out", alu_out, e.alu);
                    check("mem_rdata", rd_out, e.rdata);
                    check("misaligned", 32'(mis_out), 32'(e.mis));
                    check("bus_error", 32'(berr_out), 32'(e.berr));
                    check("stall_cycles", 32'(ret_stalls), 32'(e.stalls));
                end
            end else if (was_stall) begin
                check("stall_bubble", 32'(wbv), 32'h0);
            end
            ret_pend = !stall; was_stall = stall;
            if (stall) stall_run++;
            else begin ret_stalls = stall_run; stall_run = 0; end
        end else begin
            ret_pend = 0; was_stall = 0; stall_run = 0;
        end
    end

    // Bus monitor: request fields must match and stay stable while valid
    always @(negedge clk) begin
        req_t r;
        if (mon_en && valid) begin
            if (req_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_request: actual=valid required=idle addr=0x%08h", addr);
            end else begin
                r = req_q[0];
                check("req_addr", addr, r.addr);
                check("req_write", 32'(wr), 32'(r.wr));
                check("req_byteen", 32'(be), 32'(r.be));
                if (r.wr) check("req_wdata", wdata, r.wdata);
                if (rdy || !stall) void'(req_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t in; int kind;
        mem_ctl = '0; wb_ctl = '0; alu = 0; rs2 = 0; rdy = 0; rspv = 0; rdata = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        for (int w = 0; w < 16; w++)
            smem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

        #3;
        check("rst_wb", 32'(wb_out), 32'h0);
        check("rst_alu", alu_out, 32'h0);
        check("rst_rdata", rd_out, 32'h0);
        check("rst_mis", 32'(mis_out), 32'h0);
        check("rst_berr", 32'(berr_out), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        @(posedge clk); #1;
        mon_en = 1;
        run(mk(0, 0, 2'd0, 0, 2'b10, 32'h0000_1234, 32'h0, 0, 0, 0, 0));
        run(mk(0, 1, MEMWIDTH_W, 0, 2'b00, 32'h100, 32'h0080_FF00, 0, 0, 0, 1));
        run(mk(0, 1, MEMWIDTH_B, 0, 2'b00, 32'h103, 32'h0000_00AB, 0, 0, 0, 1));
        run(mk(1, 0, MEMWIDTH_B, 0, 2'b11, 32'h102, 32'h0, 0, 2, 0, 0));
        run(mk(1, 0, MEMWIDTH_B, 1, 2'b11, 32'h102, 32'h0, 0, 0, 0, 0));
        run(mk(1, 0, MEMWIDTH_H, 0, 2'b11, 32'h101, 32'h0, 0, 0, 0, 0));
        run(mk(1, 0, MEMWIDTH_W, 0, 2'b11, 32'h102, 32'h0, 0, 0, 0, 0));
        run(mk(0, 1, MEMWIDTH_W, 0, 2'b00, 32'h108, 32'hCAFE_F00D, 3, 0, 0, 1));
        run(mk(1, 0, MEMWIDTH_W, 0, 2'b11, 32'h10C, 32'h0, 0, 0, 1, 0));
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            in.rd = (kind == 1 || kind == 3); in.wr = (kind == 2);
            in.w = 2'($urandom_range(0, 2)); in.uns = 1'($urandom_range(0, 1));
            in.wb = 2'($urandom); in.d = $urandom;
            in.a = (kind == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 63));
            in.rw = $urandom_range(0, 2); in.sw = $urandom_range(0, 3 - in.rw);
            in.hang = ($urandom_range(0, 9) == 0);
            in.hreq = in.wr ? 1'b1 : 1'($urandom_range(0, 1));
            run(in);
        end
        run(mk(0, 0, 2'd0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0));
        @(negedge clk); #1;
        mon_en = 0;
        check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        check("req_queue_drained", 32'(req_q.size()), 32'h0);

        // Reset while a load waits in RESP, then a stray response afterwards
        @(posedge clk); #1;
        mem_ctl = '{MemRead: 1'b1, MemWrite: 1'b0, MemWidth: MEMWIDTH_W, MemUnsigned: 1'b0};
        wb_ctl = 2'b10; alu = 32'h104; rdy = 1; rspv = 0;
        @(posedge clk); #1;
        rdy = 0;
        check("resp_stall", 32'(stall), 32'h1);
        @(posedge clk); #2;
        rst_n = 0;
        mem_ctl = '0; wb_ctl = 2'b11; alu = 32'h55;
        #1;
        check("arst_wb", 32'(wb_out), 32'h0);
        check("arst_alu", alu_out, 32'h0);
        check("arst_rdata", rd_out, 32'h0);
        check("arst_stall", 32'(stall), 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        rspv = 1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("late_rsp_alu", alu_out, 32'h55);
        check("late_rsp_wb", 32'(wb_out), 32'h3);
        check("late_rsp_rdata", rd_out, 32'h0);
        check("late_rsp_berr", 32'(berr_out), 32'h0);
        rspv = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM pipeline register (ALU result, store data, MEM/WB control) and drives a valid/ready data-memory port. Performs byte-enable generation, load extraction and sign extension, and misalignment detection. Stalls the upstream pipeline while a memory transaction is outstanding, and registers the MEM/WB pipeline outputs.

Parameters:
TIMEOUT_CYCLES, 0, max cycles spent in REQ or RESP before o_BusError (0 = timeout disabled)

Ports:
i_Clock  in  1  clock
i_Reset_n  in  1  reset; asynchronous, active-low
i_MEM_Control  in  MEM_Control_t  MemRead, MemWrite, MemWidth[1:0] (0=B,1=H,2=W), MemUnsigned
i_WB_Control  in  WB_Control_t  writeback control; RegWrite and MemToReg are used here
i_AluOutput  in  32  effective address or ALU result
i_rs2Value  in  32  store data
o_Stall  out  1  freeze PC/IF/ID/EX registers this cycle
o_DMem_Valid  out  1  request valid
o_DMem_Write  out  1  1=store, 0=load
o_DMem_Addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_DMem_ByteEn  out  4  byte enables
o_DMem_WData  out  32  lane-replicated store data
i_DMem_Ready  in  1  request accepted
i_DMem_RspValid  in  1  load data valid
i_DMem_RData  in  32  load data word
o_WB_Control  out  WB_Control_t  registered writeback control
o_AluOutput  out  32  registered ALU result
o_MemReadData  out  32  registered, extended load value
o_Misaligned  out  1  registered one-cycle pulse: misaligned access dropped
o_BusError  out  1  registered one-cycle pulse: timeout

Behaviour:
- Async reset (i_Reset_n=0):
  - state=IDLE, timeout counter=0.
  - All registered outputs are 0, including o_WB_Control (all fields 0).
- Reset mid-transaction abandons the transaction; the memory port must tolerate valid dropping without ready.
- Upstream holds all i_* stable while o_Stall=1.
- Misalignment:
  - H requires addr[0]=0; W requires addr[1:0]=0.
  - A misaligned access issues no request and no stall.
  - The next edge registers a bubble (RegWrite=0) and pulses o_Misaligned.
- Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
- Store data replication: B = {4{rs2[7:0]}}; H = {2{rs2[15:0]}}; W = rs2.
- Load extraction: shift i_DMem_RData right by 8*addr[1:0], take 8/16/32 bits, then zero-extend if MemUnsigned else sign-extend.
- FSM states IDLE, REQ, RESP. o_DMem_Valid is combinational.
  - IDLE, no mem op:
    - pass-through with 1-cycle latency; o_Stall=0.
  - IDLE, aligned mem op:
    - Valid=1.
    - Write & Ready: completes; o_Stall=0; stay IDLE.
    - Read & Ready: go RESP; o_Stall=1.
    - !Ready: go REQ; o_Stall=1.
  - REQ:
    - Valid=1; o_Stall=1 until Ready.
    - On Ready: a write completes that cycle (o_Stall=0, go IDLE); a read goes RESP (o_Stall=1).
  - RESP:
    - Valid=0; o_Stall=1 until RspValid.
    - On the RspValid cycle: o_Stall=0; data is extended and registered at the edge; go IDLE.
    - Minimum load latency is 2 cycles (IDLE→RESP→IDLE).
- Any cycle with o_Stall=1 registers a bubble: o_WB_Control=0, others hold.
- i_DMem_RspValid outside RESP is ignored.
- Timeout, when TIMEOUT_CYCLES>0:
  - A counter increments each cycle spent in REQ or RESP and clears on leaving them.
  - When it reaches TIMEOUT_CYCLES: o_Stall=0, register a bubble, pulse o_BusError, go IDLE.

Decomposition:
- Shared package (pipeline_signals): MEM_Control_t gains MemWidth and MemUnsigned fields; MEMWIDTH_B/H/W constants; mem_state_t enum.
- One sub-module, load_store_align: combinational byte-enable, write-data replication, load extraction/extension and misalignment check. This makes it unit-testable standalone.

Test Plan:
- Non-memory op, addr=0x1234, RegWrite=1 -> next cycle o_AluOutput=0x1234, RegWrite=1; o_Stall never asserts.
- SB addr=0x103, rs2=0xAB, Ready=1 same cycle -> ByteEn=4'b1000, WData=0xABABABAB, Addr=0x100, o_Stall=0.
- LB addr=0x102, Ready=1, RspValid after 2 waits, RData=0x0080FF00:
  - o_Stall high for 3 cycles;
  - o_MemReadData=0xFFFFFF80; LBU gives 0x00000080.
- LH addr=0x101 -> no Valid; next cycle o_Misaligned=1, RegWrite=0; LW addr=0x102 likewise.
- SW with Ready low 3 cycles -> Valid held, Addr/WData stable, o_Stall=1 for 3 cycles; completes on 4th with o_Stall=0.
- TIMEOUT_CYCLES=4, load with RspValid never -> o_BusError pulses after 4 cycles in RESP, bubble, FSM IDLE.
- Reset pulsed while in RESP -> outputs 0 immediately (async), FSM IDLE; a late RspValid is ignored.
